// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared sizing for the MEM-stage data memory: default word width, address
// width and depth, plus a helper that returns the index width for a depth.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_DATA_W    = 8;
    localparam int MEM_ADDR_W    = 32;
    localparam int MEM_DEPTH_DEF = 256;

    // Index width for a power-of-two depth; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_valid_array.sv
// -----------------------------------------------------------------------------
// mem_valid_array
// One valid flag per memory location. Flags clear asynchronously on reset,
// are set by a write on the rising clock edge, and are looked up
// combinationally by index.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-high clear of every flag
//   i_set      set the flag at i_set_idx on the next rising edge
//   i_set_idx  index of the flag to set
//   i_rd_idx   index of the flag to look up
//   o_valid    flag value at i_rd_idx
// -----------------------------------------------------------------------------
module mem_valid_array
    import mem_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH_DEF,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_set,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_valid
);

    logic [DEPTH-1:0] r_valid;

    // Reset holds every flag at zero, so a write presented while reset is
    // high can never mark a location valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_set) begin
            r_valid[i_set_idx] <= 1'b1;
        end
    end

    assign o_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Byte-wide data memory for the MEM stage of the 5-stage MIPS pipeline.
// Synchronous writes, combinational reads gated by MemRead. A per-location
// valid flag makes never-written (or reset-invalidated) locations read as zero.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset (clears valid flags only)
//   address     byte address from the ALU result
//   write_data  store data
//   MemWrite    store enable
//   MemRead     load enable
//   read_data   load data; zero when not reading, out of range or invalid
// -----------------------------------------------------------------------------
module data_mem
    import mem_pkg::*;
#(
    parameter int DEPTH  = MEM_DEPTH_DEF,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [DATA_W-1:0] read_data
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_wr_en;
    logic             w_valid;
    logic             w_hit;

    // Compare the full address so that aliases above DEPTH are rejected
    // rather than wrapping onto low locations.
    assign w_in_range = (address < ADDR_W'(DEPTH));
    assign w_idx      = address[IDX_W-1:0];
    assign w_wr_en    = MemWrite & w_in_range;

    mem_valid_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_valid (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_set     (w_wr_en),
        .i_set_idx (w_idx),
        .i_rd_idx  (w_idx),
        .o_valid   (w_valid)
    );

    // The data RAM has no reset. It may capture a store presented while
    // reset is high, but the valid flag stays clear, so that data is never
    // visible and the location behaves as unwritten until a later store.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= write_data;
        end
    end

    assign w_hit = MemRead & w_in_range & w_valid;

    always_comb begin
        read_data = '0;
        if (w_hit) begin
            read_data = r_mem[w_idx];
        end
    end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

    localparam int DEPTH = 256;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [31:0] address    = '0;
    logic [7:0]  write_data = '0;
    logic        MemWrite   = 1'b0;
    logic        MemRead    = 1'b0;
    wire  [7:0]  read_data;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: what has been stored, and whether it has been stored
    // since the last reset.
    logic [7:0] m_data  [DEPTH];
    bit         m_valid [DEPTH];

    always #5 clk = ~clk;

    data_mem #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write_data (write_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .read_data  (read_data)
    );

    function automatic logic [7:0] model_read(input logic [31:0] a, input logic rd);
        if (!rd) return 8'h00;
        if (a >= DEPTH) return 8'h00;
        if (!m_valid[a]) return 8'h00;
        return m_data[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    // One store across a single rising edge; the model follows the edge.
    task automatic do_write(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        write_data = d;
        MemWrite   = 1'b1;
        MemRead    = 1'b0;
        @(posedge clk);
        if (!reset && a < DEPTH) begin
            m_data[a]  = d;
            m_valid[a] = 1'b1;
        end
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        @(negedge clk);
        address  = a;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        address = 32'd0;
        MemRead = 1'b1;
        #1;
        n_total++;
        if (read_data !== 8'h00) $display("FAIL reset_read0: got %h expected %h", read_data, 8'h00);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (read_data !== 8'h00) $display("FAIL post_reset_read0: got %h expected %h", read_data, 8'h00);
        else n_pass++;
    endtask

    task automatic test_basic();
        do_write(32'd0, 8'hAA);
        do_read(32'd0);
        n_total++;
        if (read_data !== 8'hAA) $display("FAIL basic_read0: got %h expected %h", read_data, 8'hAA);
        else n_pass++;
        do_write(32'd1, 8'h55);
        do_read(32'd1);
        n_total++;
        if (read_data !== 8'h55) $display("FAIL basic_read1: got %h expected %h", read_data, 8'h55);
        else n_pass++;
        do_read(32'd0);
        n_total++;
        if (read_data !== 8'hAA) $display("FAIL basic_reread0: got %h expected %h", read_data, 8'hAA);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [4];
        addrs = '{32'd2, DEPTH, 32'd256 + 32'd1, 32'hFFFF_FFFF};
        foreach (addrs[i]) begin
            do_read(addrs[i]);
            n_total++;
            if (read_data !== 8'h00) $display("FAIL oor_read addr=%h: got %h expected %h", addrs[i], read_data, 8'h00);
            else n_pass++;
        end
        do_write(DEPTH, 8'hFF);
        do_read(32'd0);
        n_total++;
        if (read_data !== 8'hAA) $display("FAIL oor_write_alias0: got %h expected %h", read_data, 8'hAA);
        else n_pass++;
        do_read(DEPTH);
        n_total++;
        if (read_data !== 8'h00) $display("FAIL oor_read_after_write: got %h expected %h", read_data, 8'h00);
        else n_pass++;
    endtask

    task automatic test_memread_off();
        do_read(32'd0);
        MemRead = 1'b0;
        #1;
        n_total++;
        if (read_data !== 8'h00) $display("FAIL memread_off: got %h expected %h", read_data, 8'h00);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        logic [7:0] vals [2];
        vals = '{8'h5A, 8'hC3};
        foreach (vals[i]) begin
            logic [7:0] exp_before;
            exp_before = model_read(32'd3, 1'b1);
            @(negedge clk);
            address    = 32'd3;
            write_data = vals[i];
            MemRead    = 1'b1;
            MemWrite   = 1'b1;
            #1;
            n_total++;
            if (read_data !== exp_before) $display("FAIL rw_before_edge[%0d]: got %h expected %h", i, read_data, exp_before);
            else n_pass++;
            @(posedge clk);
            m_data[3]  = vals[i];
            m_valid[3] = 1'b1;
            #1;
            n_total++;
            if (read_data !== vals[i]) $display("FAIL rw_after_edge[%0d]: got %h expected %h", i, read_data, vals[i]);
            else n_pass++;
            MemWrite = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        do_write(32'd7, 8'h11);
        do_write(32'd7, 8'h22);
        do_write(32'd7, 8'h33);
        do_read(32'd7);
        n_total++;
        if (read_data !== 8'h33) $display("FAIL back_to_back: got %h expected %h", read_data, 8'h33);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_read(32'd0);
        n_total++;
        if (read_data !== 8'hAA) $display("FAIL pre_reset_read0: got %h expected %h", read_data, 8'hAA);
        else n_pass++;
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        n_total++;
        if (read_data !== 8'h00) $display("FAIL async_reset_drop: got %h expected %h", read_data, 8'h00);
        else n_pass++;
        do_write(32'd0, 8'h12);
        do_read(32'd0);
        n_total++;
        if (read_data !== 8'h00) $display("FAIL write_in_reset: got %h expected %h", read_data, 8'h00);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (read_data !== 8'h00) $display("FAIL after_release_read0: got %h expected %h", read_data, 8'h00);
        else n_pass++;
        do_write(32'd0, 8'h12);
        do_read(32'd0);
        n_total++;
        if (read_data !== 8'h12) $display("FAIL rewrite_after_reset: got %h expected %h", read_data, 8'h12);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            logic [31:0] a;
            logic [7:0]  d;
            logic        we;
            logic        rd;
            logic [7:0]  exp_v;
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 15));
                1:       a = 32'($urandom_range(0, DEPTH - 1));
                2:       a = 32'($urandom_range(DEPTH, DEPTH + 8));
                default: a = $urandom;
            endcase
            d  = 8'($urandom);
            we = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            address    = a;
            write_data = d;
            MemWrite   = we;
            MemRead    = rd;
            #1;
            exp_v = model_read(a, rd);
            n_total++;
            if (read_data !== exp_v) $display("FAIL rand_pre[%0d] addr=%h: got %h expected %h", it, a, read_data, exp_v);
            else n_pass++;
            @(posedge clk);
            if (we && a < DEPTH) begin
                m_data[a]  = d;
                m_valid[a] = 1'b1;
            end
            #1;
            exp_v = model_read(a, rd);
            n_total++;
            if (read_data !== exp_v) $display("FAIL rand_post[%0d] addr=%h: got %h expected %h", it, a, read_data, exp_v);
            else n_pass++;
            MemWrite = 1'b0;
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                model_clear();
                #1;
                exp_v = model_read(a, rd);
                n_total++;
                if (read_data !== exp_v) $display("FAIL rand_reset[%0d]: got %h expected %h", it, read_data, exp_v);
                else n_pass++;
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_out_of_range();
        test_memread_off();
        test_same_cycle();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d of %0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
